// File: rtl/line_timer_pkg.sv
// Shared horizontal/vertical timing definitions: line-phase states, default
// 640x480-style horizontal timing, and the total-period helper.
package line_timer_pkg;

    typedef enum logic [2:0] {
        LS_IDLE,
        LS_ACTIVE,
        LS_FP,
        LS_SYNC,
        LS_BP
    } line_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/line_timer_if.sv
// Control/status bundle between the line timer and the line counter / video sink.
// master = timer side, slave = consumer side that drives enb and endFrame.
interface line_timer_if #(
    parameter int CNT_W = 12
) ();
    logic             enb;
    logic             endFrame;
    logic             newLine;
    logic             active;
    logic             hsync;
    logic [CNT_W-1:0] pix_x;
    logic             frame_done;
    logic             busy;

    modport master (
        input  enb,
        input  endFrame,
        output newLine,
        output active,
        output hsync,
        output pix_x,
        output frame_done,
        output busy
    );

    modport slave (
        output enb,
        output endFrame,
        input  newLine,
        input  active,
        input  hsync,
        input  pix_x,
        input  frame_done,
        input  busy
    );
endinterface

// File: rtl/line_timer.sv
// Horizontal line timer: walks ACTIVE/FP/SYNC/BP per line, pulses newLine, stops at frame end.
// Latency: all outputs registered; first line starts the cycle after enb is sampled high.
// Backpressure: none; enb and endFrame are only honoured at line boundaries, a line always completes.
module line_timer
    import line_timer_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int CNT_W    = 12,
    parameter bit HS_POL   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    line_timer_if.master  lt
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);

    localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] FP_LAST   = CNT_W'(H_ACTIVE + H_FP - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(H_TOTAL - 1);

    line_state_t      state;
    line_state_t      state_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             end_pend;
    logic             pend_nx;
    logic             nl_nx;
    logic             fd_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LS_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // pix_x doubles as the phase counter; an endFrame seen in the last BP
    // cycle still stops this line, hence the OR with the live input.
    always_comb begin
        state_nx = state;
        cnt_nx   = lt.pix_x + CNT_W'(1);
        pend_nx  = end_pend | lt.endFrame;
        nl_nx    = 1'b0;
        fd_nx    = 1'b0;
        case (state)
            LS_IDLE: begin
                cnt_nx  = '0;
                pend_nx = 1'b0;
                if (lt.enb) begin
                    state_nx = LS_ACTIVE;
                    nl_nx    = 1'b1;
                end
            end
            LS_ACTIVE: if (lt.pix_x == ACT_LAST)  state_nx = LS_FP;
            LS_FP:     if (lt.pix_x == FP_LAST)   state_nx = LS_SYNC;
            LS_SYNC:   if (lt.pix_x == SYNC_LAST) state_nx = LS_BP;
            LS_BP: begin
                if (lt.pix_x == LINE_LAST) begin
                    cnt_nx  = '0;
                    pend_nx = 1'b0;
                    if (end_pend || lt.endFrame) begin
                        state_nx = LS_IDLE;
                        fd_nx    = 1'b1;
                    end else if (!lt.enb) begin
                        state_nx = LS_IDLE;
                    end else begin
                        state_nx = LS_ACTIVE;
                        nl_nx    = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = LS_IDLE;
                cnt_nx   = '0;
                pend_nx  = 1'b0;
            end
        endcase
    end

    // Outputs are registered from next-state so they align with state/pix_x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            end_pend      <= 1'b0;
            lt.pix_x      <= '0;
            lt.newLine    <= 1'b0;
            lt.active     <= 1'b0;
            lt.hsync      <= ~HS_POL;
            lt.frame_done <= 1'b0;
            lt.busy       <= 1'b0;
        end else begin
            end_pend      <= pend_nx;
            lt.pix_x      <= cnt_nx;
            lt.newLine    <= nl_nx;
            lt.active     <= (state_nx == LS_ACTIVE);
            lt.hsync      <= (state_nx == LS_SYNC) ? HS_POL : ~HS_POL;
            lt.frame_done <= fd_nx;
            lt.busy       <= (state_nx != LS_IDLE);
        end
    end

endmodule

// File: tb/tb_line_timer.sv
// Bench for line_timer with a small 15-cycle line: directed boundary cases then
// random enb/endFrame traffic, all checked against a position-based line model.
module tb_line_timer;

    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int CNT_W    = 5;
    localparam bit HS_POL   = 1'b1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    // Model state: pos = column of the current cycle, -1 when idle.
    int pos    = -1;
    bit pend   = 1'b0;
    bit fd_exp = 1'b0;

    line_timer_if #(.CNT_W(CNT_W)) bus ();

    line_timer #(
        .H_ACTIVE(H_ACTIVE),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .CNT_W   (CNT_W),
        .HS_POL  (HS_POL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .lt   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (pos=%0d, t=%0t)", tag, obs, exp, pos, $time);
        end
    endtask

    task automatic model_reset();
        pos    = -1;
        pend   = 1'b0;
        fd_exp = 1'b0;
    endtask

    // One clock edge of the reference: a line is H_TOTAL columns long and its
    // end decides stop-for-frame, stop-for-enb, or start the next line.
    task automatic model_edge();
        fd_exp = 1'b0;
        if (pos < 0) begin
            if (bus.enb) pos = 0;
        end else begin
            if (bus.endFrame) pend = 1'b1;
            if (pos == H_TOTAL - 1) begin
                if (pend) begin
                    pos    = -1;
                    pend   = 1'b0;
                    fd_exp = 1'b1;
                end else if (!bus.enb) begin
                    pos = -1;
                end else begin
                    pos = 0;
                end
            end else begin
                pos++;
            end
        end
    endtask

    task automatic compare_all();
        int exp_hs;
        exp_hs = (pos >= H_ACTIVE + H_FP && pos < H_ACTIVE + H_FP + H_SYNC) ? int'(HS_POL) : int'(!HS_POL);
        check("pix_x",      int'(bus.pix_x),      (pos < 0) ? 0 : pos);
        check("busy",       int'(bus.busy),       (pos >= 0) ? 1 : 0);
        check("newLine",    int'(bus.newLine),    (pos == 0) ? 1 : 0);
        check("active",     int'(bus.active),     (pos >= 0 && pos < H_ACTIVE) ? 1 : 0);
        check("hsync",      int'(bus.hsync),      exp_hs);
        check("frame_done", int'(bus.frame_done), int'(fd_exp));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_until(input int target);
        int n = 0;
        while (pos != target && n < 4 * H_TOTAL) begin
            step();
            n++;
        end
        if (pos != target) check("reach_pos", pos, target);
    endtask

    initial begin
        int fd_cnt;
        bus.enb      = 1'b0;
        bus.endFrame = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle with enb low.
        repeat (10) step();

        // Free-running lines.
        bus.enb = 1'b1;
        repeat (3 * H_TOTAL + 2) step();

        // enb dropped mid-line: the line finishes, then idle.
        run_until(4);
        bus.enb = 1'b0;
        repeat (H_TOTAL + 5) step();

        // endFrame mid-line with enb held: one frame_done, restart two cycles after line end.
        bus.enb = 1'b1;
        run_until(3);
        bus.endFrame = 1'b1;
        step();
        bus.endFrame = 1'b0;
        fd_cnt = 0;
        for (int i = 0; i < H_TOTAL + 4; i++) begin
            step();
            if (bus.frame_done) fd_cnt++;
        end
        check("fd_count", fd_cnt, 1);

        // endFrame in the very last column, plus repeated pulses on the next line.
        run_until(H_TOTAL - 1);
        bus.endFrame = 1'b1;
        step();
        bus.endFrame = 1'b0;
        repeat (3) step();
        run_until(2);
        repeat (3) begin
            bus.endFrame = 1'b1;
            step();
            bus.endFrame = 1'b0;
            step();
        end
        repeat (H_TOTAL) step();

        // Asynchronous reset mid-line.
        run_until(9);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        bus.enb = 1'b1;
        rst_n   = 1'b1;
        step();
        check("restart_col", int'(bus.pix_x), 0);
        repeat (H_TOTAL) step();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(19) == 0) bus.enb = ~bus.enb;
            bus.endFrame = ($urandom_range(15) == 0);
            step();
        end
        bus.endFrame = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
